// File: rtl/mpi_slave_bridge.sv
// mpi_slave_bridge: asynchronous CPU bus slave to single-cycle register-file strobe bridge.
// Ports:
//   clk_100m, rst                  clock, asynchronous active-high reset
//   cpu_cs_n/rd_n/we_n/addr/data_in  CPU bus inputs (sampled once before use)
//   cpu_data_out, cpu_data_oe      read data and pad output enable
//   cpu_rdy_n                      access complete, active-low
//   reg_wr_en/rd_en/addr/wdata     register-file request side
//   reg_rdata, reg_rd_vld          register-file read response
//   err_timeout, err_illegal       single-cycle error pulses
module mpi_slave_bridge #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        clk_100m,
    input  logic        rst,
    input  logic        cpu_cs_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_we_n,
    input  logic [15:0] cpu_addr,
    input  logic [31:0] cpu_data_in,
    output logic [31:0] cpu_data_out,
    output logic        cpu_data_oe,
    output logic        cpu_rdy_n,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    output logic [15:0] reg_addr,
    output logic [31:0] reg_wdata,
    input  logic [31:0] reg_rdata,
    input  logic        reg_rd_vld,
    output logic        err_timeout,
    output logic        err_illegal
);
    typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, ACK, DONE} state_t;
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
    state_t      state_q, state_d;
    logic        cs_n_q, rd_n_q, we_n_q;
    logic [15:0] addr_s_q;
    logic [31:0] din_s_q;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rd_op_q, rd_op_d;
    logic        lock_q, lock_d;
    logic        err_to_q, err_to_d;
    logic        err_il_q, err_il_d;
    // CPU pins are asynchronous to clk_100m: capture them once before any decision.
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            addr_s_q <= '0;
            din_s_q  <= '0;
        end else begin
            cs_n_q   <= cpu_cs_n;
            rd_n_q   <= cpu_rd_n;
            we_n_q   <= cpu_we_n;
            addr_s_q <= cpu_addr;
            din_s_q  <= cpu_data_in;
        end
    end
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            rd_op_q  <= 1'b0;
            lock_q   <= 1'b0;
            err_to_q <= 1'b0;
            err_il_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            rd_op_q  <= rd_op_d;
            lock_q   <= lock_d;
            err_to_q <= err_to_d;
            err_il_q <= err_il_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        rd_op_d  = rd_op_q;
        lock_d   = lock_q;
        err_to_d = 1'b0;
        err_il_d = 1'b0;
        case (state_q)
            IDLE: begin
                // lock_q holds off any access after an illegal strobe until cs_n is seen high
                if (cs_n_q) begin
                    lock_d = 1'b0;
                end else if (!lock_q) begin
                    if (!rd_n_q && !we_n_q) begin
                        err_il_d = 1'b1;
                        lock_d   = 1'b1;
                    end else if (!we_n_q) begin
                        state_d = WR;
                        addr_d  = addr_s_q;
                        wdata_d = din_s_q;
                        rd_op_d = 1'b0;
                    end else if (!rd_n_q) begin
                        state_d = RD;
                        addr_d  = addr_s_q;
                        rd_op_d = 1'b1;
                    end
                end
            end
            WR: state_d = cs_n_q ? IDLE : ACK;
            RD: begin
                cnt_d   = '0;
                state_d = cs_n_q ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
                // abort beats data, data beats timeout
                if (cs_n_q) begin
                    state_d = IDLE;
                end else if (reg_rd_vld) begin
                    data_d  = reg_rdata;
                    state_d = ACK;
                end else if (cnt_q == TO_LIM) begin
                    data_d   = ERR_DATA;
                    err_to_d = 1'b1;
                    state_d  = ACK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ACK:     state_d = cs_n_q ? DONE : ACK;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign reg_wr_en    = (state_q == WR);
    assign reg_rd_en    = (state_q == RD);
    assign cpu_rdy_n    = (state_q != ACK);
    assign cpu_data_oe  = (state_q == ACK) && rd_op_q;
    assign cpu_data_out = data_q;
    assign reg_addr     = addr_q;
    assign reg_wdata    = wdata_q;
    assign err_timeout  = err_to_q;
    assign err_illegal  = err_il_q;
endmodule

// File: tb/tb_mpi_slave_bridge.sv
// tb_mpi_slave_bridge: directed self-checking bench for mpi_slave_bridge (TIMEOUT_CYC=4).
// Inputs are driven and outputs checked on the falling edge of clk_100m.
module tb_mpi_slave_bridge;
    logic        clk_100m = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_cs_n = 1'b1, cpu_rd_n = 1'b1, cpu_we_n = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic [31:0] cpu_data_in = '0;
    logic [31:0] cpu_data_out;
    logic        cpu_data_oe, cpu_rdy_n, reg_wr_en, reg_rd_en;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata = '0;
    logic        reg_rd_vld = 1'b0;
    logic        err_timeout, err_illegal;
    int          n_chk = 0;
    int          n_fail = 0;

    mpi_slave_bridge #(.TIMEOUT_CYC(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk_100m(clk_100m), .rst(rst),
        .cpu_cs_n(cpu_cs_n), .cpu_rd_n(cpu_rd_n), .cpu_we_n(cpu_we_n),
        .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
        .cpu_data_out(cpu_data_out), .cpu_data_oe(cpu_data_oe), .cpu_rdy_n(cpu_rdy_n),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_rd_vld(reg_rd_vld),
        .err_timeout(err_timeout), .err_illegal(err_illegal)
    );

    always #5 clk_100m = ~clk_100m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk_100m);
    endtask

    task automatic bus(input logic cs, input logic rd, input logic we,
                       input logic [15:0] a, input logic [31:0] d);
        cpu_cs_n = cs;
        cpu_rd_n = rd;
        cpu_we_n = we;
        cpu_addr = a;
        cpu_data_in = d;
    endtask

    initial begin
        // reset state
        step(2);
        chk("rst_rdy_n", 32'(cpu_rdy_n), 32'd1);
        chk("rst_oe", 32'(cpu_data_oe), 32'd0);
        chk("rst_dout", cpu_data_out, 32'h0);
        chk("rst_addr", 32'(reg_addr), 32'h0);
        chk("rst_wdata", reg_wdata, 32'h0);
        chk("rst_en", {30'd0, reg_wr_en, reg_rd_en}, 32'd0);
        chk("rst_err", {30'd0, err_timeout, err_illegal}, 32'd0);
        rst = 1'b0;
        step(2);

        // write 0x0010 <- 0x12345678
        bus(1'b0, 1'b1, 1'b0, 16'h0010, 32'h1234_5678);
        step();
        chk("wr_no_en_yet", 32'(reg_wr_en), 32'd0);
        step();
        chk("wr_en", 32'(reg_wr_en), 32'd1);
        chk("wr_addr", 32'(reg_addr), 32'h0010);
        chk("wr_wdata", reg_wdata, 32'h1234_5678);
        chk("wr_rdy_pre", 32'(cpu_rdy_n), 32'd1);
        step();
        chk("wr_en_pulse", 32'(reg_wr_en), 32'd0);
        chk("wr_rdy", 32'(cpu_rdy_n), 32'd0);
        chk("wr_oe", 32'(cpu_data_oe), 32'd0);
        bus(1'b1, 1'b1, 1'b1, 16'h0, 32'h0);
        step();
        chk("wr_rdy_hold", 32'(cpu_rdy_n), 32'd0);
        step();
        chk("wr_done_rdy", 32'(cpu_rdy_n), 32'd1);
        step();

        // read 0x0020, data 3 cycles after reg_rd_en
        bus(1'b0, 1'b0, 1'b1, 16'h0020, 32'h0);
        step(2);
        chk("rd_en", 32'(reg_rd_en), 32'd1);
        chk("rd_addr", 32'(reg_addr), 32'h0020);
        step();
        chk("rd_en_pulse", 32'(reg_rd_en), 32'd0);
        step(2);
        reg_rd_vld = 1'b1;
        reg_rdata = 32'hCAFE_0001;
        chk("rd_wait_rdy", 32'(cpu_rdy_n), 32'd1);
        step();
        reg_rd_vld = 1'b0;
        reg_rdata = 32'h0;
        chk("rd_dout", cpu_data_out, 32'hCAFE_0001);
        chk("rd_oe", 32'(cpu_data_oe), 32'd1);
        chk("rd_rdy", 32'(cpu_rdy_n), 32'd0);
        bus(1'b1, 1'b1, 1'b1, 16'h0, 32'h0);
        step();
        chk("rd_oe_hold", 32'(cpu_data_oe), 32'd1);
        step();
        chk("rd_done_oe", 32'(cpu_data_oe), 32'd0);
        chk("rd_done_rdy", 32'(cpu_rdy_n), 32'd1);
        step();

        // read timeout: counter 0..4 in RD_WAIT, abort on the 5th wait cycle
        bus(1'b0, 1'b0, 1'b1, 16'h0024, 32'h0);
        step(2);
        chk("to_rd_en", 32'(reg_rd_en), 32'd1);
        step(5);
        chk("to_not_yet", 32'(err_timeout), 32'd0);
        chk("to_rdy_pre", 32'(cpu_rdy_n), 32'd1);
        step();
        chk("to_err", 32'(err_timeout), 32'd1);
        chk("to_dout", cpu_data_out, 32'hDEAD_BEEF);
        chk("to_rdy", 32'(cpu_rdy_n), 32'd0);
        chk("to_oe", 32'(cpu_data_oe), 32'd1);
        step();
        chk("to_err_pulse", 32'(err_timeout), 32'd0);
        bus(1'b1, 1'b1, 1'b1, 16'h0, 32'h0);
        step(3);

        // data arriving in the timeout cycle wins
        bus(1'b0, 1'b0, 1'b1, 16'h0028, 32'h0);
        step(2);
        step(5);
        reg_rd_vld = 1'b1;
        reg_rdata = 32'h5A5A_0028;
        step();
        reg_rd_vld = 1'b0;
        reg_rdata = 32'h0;
        chk("tie_no_err", 32'(err_timeout), 32'd0);
        chk("tie_dout", cpu_data_out, 32'h5A5A_0028);
        chk("tie_rdy", 32'(cpu_rdy_n), 32'd0);
        bus(1'b1, 1'b1, 1'b1, 16'h0, 32'h0);
        step(3);

        // illegal: rd_n and we_n both low
        bus(1'b0, 1'b0, 1'b0, 16'h0070, 32'h0);
        step();
        chk("il_not_yet", 32'(err_illegal), 32'd0);
        step();
        chk("il_err", 32'(err_illegal), 32'd1);
        chk("il_no_en", {30'd0, reg_wr_en, reg_rd_en}, 32'd0);
        step();
        chk("il_err_pulse", 32'(err_illegal), 32'd0);
        bus(1'b0, 1'b0, 1'b1, 16'h0070, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("il_locked", {29'd0, reg_wr_en, reg_rd_en, err_illegal}, 32'd0);
            chk("il_rdy", 32'(cpu_rdy_n), 32'd1);
        end
        bus(1'b1, 1'b1, 1'b1, 16'h0, 32'h0);
        step(3);

        // abort in RD_WAIT then late reg_rd_vld
        bus(1'b0, 1'b0, 1'b1, 16'h0030, 32'h0);
        step(2);
        chk("ab_rd_en", 32'(reg_rd_en), 32'd1);
        step();
        bus(1'b1, 1'b1, 1'b1, 16'h0, 32'h0);
        step(2);
        reg_rd_vld = 1'b1;
        reg_rdata = 32'hFFFF_0000;
        step();
        reg_rd_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ab_rdy", 32'(cpu_rdy_n), 32'd1);
            chk("ab_oe", 32'(cpu_data_oe), 32'd0);
            step();
        end
        chk("ab_dout_kept", cpu_data_out, 32'h5A5A_0028);
        bus(1'b0, 1'b1, 1'b0, 16'h0040, 32'hAAAA_5555);
        step(2);
        chk("ab_wr_en", 32'(reg_wr_en), 32'd1);
        chk("ab_wr_addr", 32'(reg_addr), 32'h0040);
        chk("ab_wr_wdata", reg_wdata, 32'hAAAA_5555);
        step();
        chk("ab_wr_rdy", 32'(cpu_rdy_n), 32'd0);
        bus(1'b1, 1'b1, 1'b1, 16'h0, 32'h0);
        step(3);

        // asynchronous reset during read ACK
        bus(1'b0, 1'b0, 1'b1, 16'h0050, 32'h0);
        step(3);
        reg_rd_vld = 1'b1;
        reg_rdata = 32'h1234_0050;
        step();
        reg_rd_vld = 1'b0;
        chk("ar_oe_pre", 32'(cpu_data_oe), 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_oe", 32'(cpu_data_oe), 32'd0);
        chk("ar_rdy", 32'(cpu_rdy_n), 32'd1);
        chk("ar_dout", cpu_data_out, 32'h0);
        bus(1'b1, 1'b1, 1'b1, 16'h0, 32'h0);
        step();
        rst = 1'b0;
        step(2);
        chk("ar_idle", {30'd0, reg_rd_en, cpu_rdy_n}, 32'd1);
        bus(1'b0, 1'b1, 1'b0, 16'h0060, 32'h0BAD_F00D);
        step(2);
        chk("ar_wr_en", 32'(reg_wr_en), 32'd1);
        chk("ar_wr_wdata", reg_wdata, 32'h0BAD_F00D);
        step();
        chk("ar_wr_rdy", 32'(cpu_rdy_n), 32'd0);
        bus(1'b1, 1'b1, 1'b1, 16'h0, 32'h0);
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
